// File: rtl/sd_spi_bus_sched_if.sv
// sd_spi_bus_sched_if: bundles the SD SPI bus scheduler's handshake,
// engine and card-side signals. The master modport is the scheduler
// itself; the slave modport is the surrounding init/read/write engines,
// datapath and card.
interface sd_spi_bus_sched_if #(
    parameter int SEC_W = 32
);
    // init engine
    logic             init_o;
    logic             init_cs;
    logic             init_datain;
    // datapath read requester
    logic             rd_req;
    logic [SEC_W-1:0] rd_sec;
    logic             rd_gnt;
    logic             rd_done;
    // datapath write requester
    logic             wr_req;
    logic [SEC_W-1:0] wr_sec;
    logic             wr_gnt;
    logic             wr_done;
    // read engine
    logic             eng_rd_start;
    logic [SEC_W-1:0] eng_rd_sec;
    logic             eng_rd_cs;
    logic             eng_rd_datain;
    logic             eng_rd_done;
    // write engine
    logic             eng_wr_start;
    logic [SEC_W-1:0] eng_wr_sec;
    logic             eng_wr_cs;
    logic             eng_wr_datain;
    logic             eng_wr_done;
    // card side and status
    logic             SD_cs;
    logic             SD_datain;
    logic             busy;
    logic [2:0]       state;
    logic             err;

    modport master (
        input  init_o, init_cs, init_datain,
        input  rd_req, rd_sec, wr_req, wr_sec,
        input  eng_rd_cs, eng_rd_datain, eng_rd_done,
        input  eng_wr_cs, eng_wr_datain, eng_wr_done,
        output rd_gnt, rd_done, wr_gnt, wr_done,
        output eng_rd_start, eng_rd_sec, eng_wr_start, eng_wr_sec,
        output SD_cs, SD_datain, busy, state, err
    );

    modport slave (
        output init_o, init_cs, init_datain,
        output rd_req, rd_sec, wr_req, wr_sec,
        output eng_rd_cs, eng_rd_datain, eng_rd_done,
        output eng_wr_cs, eng_wr_datain, eng_wr_done,
        input  rd_gnt, rd_done, wr_gnt, wr_done,
        input  eng_rd_start, eng_rd_sec, eng_wr_start, eng_wr_sec,
        input  SD_cs, SD_datain, busy, state, err
    );
endinterface

// File: rtl/sd_spi_bus_sched.sv
// sd_spi_bus_sched: owns the single SD-card SPI bus. The init engine has
// the bus until it reports done, then read/write sector requests are
// arbitrated round-robin, the matching engine is started and its SPI
// outputs are passed to the card, with an idle gap after each transaction.
// Optional macro SD_SCHED_TIMEOUT_EN adds a busy-time watchdog that aborts
// a stuck engine, pulses the requester's done and sets a sticky err.
module sd_spi_bus_sched #(
    parameter int SEC_W          = 32,
    parameter int GAP_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 1048575
) (
    input logic                SD_clk,
    input logic                reset,
    sd_spi_bus_sched_if.master bus
);
    typedef enum logic [2:0] {
        WAIT_INIT = 3'd0,
        IDLE      = 3'd1,
        RD_START  = 3'd2,
        RD_BUSY   = 3'd3,
        WR_START  = 3'd4,
        WR_BUSY   = 3'd5,
        GAP       = 3'd6
    } state_t;

    localparam logic [7:0]  GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic             last_wr_q;      // 1: the write side was served last
    logic [7:0]       gap_cnt_q;
    logic [SEC_W-1:0] eng_rd_sec_q;
    logic [SEC_W-1:0] eng_wr_sec_q;
    logic             rd_done_q;
    logic             wr_done_q;
    logic             tmo;            // watchdog expiry this cycle

`ifdef SD_SCHED_TIMEOUT_EN
    logic [19:0] tmr_q;
    logic        err_q;

    assign tmo = (tmr_q == TMO_LAST);

    // Watchdog: restarts from zero on every entry to a busy state and
    // latches err when it expires before the engine finishes.
    always_ff @(posedge SD_clk or posedge reset) begin
        if (reset) begin
            tmr_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == RD_BUSY || state_q == WR_BUSY)
                tmr_q <= tmr_q + 20'd1;
            else
                tmr_q <= '0;
            if ((state_q == RD_BUSY && tmo && !bus.eng_rd_done) ||
                (state_q == WR_BUSY && tmo && !bus.eng_wr_done))
                err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    logic unused_tmo;
    assign unused_tmo = ^TMO_LAST;
    assign tmo        = 1'b0;
    assign bus.err    = 1'b0;
`endif

    // State register.
    always_ff @(posedge SD_clk or posedge reset) begin
        if (reset) state_q <= WAIT_INIT;
        else       state_q <= state_d;
    end

    // Next-state logic: init hand-off, round-robin arbitration, gap timing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_INIT: if (bus.init_o) state_d = IDLE;
            IDLE: begin
                if (!bus.init_o)
                    state_d = WAIT_INIT;
                else if (bus.rd_req && bus.wr_req)
                    state_d = last_wr_q ? RD_START : WR_START;
                else if (bus.rd_req)
                    state_d = RD_START;
                else if (bus.wr_req)
                    state_d = WR_START;
            end
            RD_START: state_d = RD_BUSY;
            RD_BUSY:  if (bus.eng_rd_done || tmo) state_d = GAP;
            WR_START: state_d = WR_BUSY;
            WR_BUSY:  if (bus.eng_wr_done || tmo) state_d = GAP;
            GAP:      if (gap_cnt_q == GAP_LAST) state_d = IDLE;
            default:  state_d = WAIT_INIT;
        endcase
    end

    // Datapath: sector latch at grant, round-robin memory, gap counter and
    // done pulses one cycle after the engine's done (or watchdog abort).
    always_ff @(posedge SD_clk or posedge reset) begin
        if (reset) begin
            last_wr_q    <= 1'b1;
            gap_cnt_q    <= '0;
            eng_rd_sec_q <= '0;
            eng_wr_sec_q <= '0;
            rd_done_q    <= 1'b0;
            wr_done_q    <= 1'b0;
        end else begin
            rd_done_q <= (state_q == RD_BUSY) && (bus.eng_rd_done || tmo);
            wr_done_q <= (state_q == WR_BUSY) && (bus.eng_wr_done || tmo);
            if (state_q == IDLE && state_d == RD_START) begin
                eng_rd_sec_q <= bus.rd_sec;
                last_wr_q    <= 1'b0;
            end
            if (state_q == IDLE && state_d == WR_START) begin
                eng_wr_sec_q <= bus.wr_sec;
                last_wr_q    <= 1'b1;
            end
            if (state_q == GAP) gap_cnt_q <= gap_cnt_q + 8'd1;
            else                gap_cnt_q <= '0;
        end
    end

    // Outputs: SPI mux selected by the registered state, plus state decodes.
    always_comb begin
        bus.SD_cs     = 1'b1;
        bus.SD_datain = 1'b1;
        case (state_q)
            WAIT_INIT: begin
                bus.SD_cs     = bus.init_cs;
                bus.SD_datain = bus.init_datain;
            end
            RD_START, RD_BUSY: begin
                bus.SD_cs     = bus.eng_rd_cs;
                bus.SD_datain = bus.eng_rd_datain;
            end
            WR_START, WR_BUSY: begin
                bus.SD_cs     = bus.eng_wr_cs;
                bus.SD_datain = bus.eng_wr_datain;
            end
            default: begin
                bus.SD_cs     = 1'b1;
                bus.SD_datain = 1'b1;
            end
        endcase
        bus.rd_gnt       = (state_q == RD_START);
        bus.eng_rd_start = (state_q == RD_START);
        bus.wr_gnt       = (state_q == WR_START);
        bus.eng_wr_start = (state_q == WR_START);
        bus.rd_done      = rd_done_q;
        bus.wr_done      = wr_done_q;
        bus.eng_rd_sec   = eng_rd_sec_q;
        bus.eng_wr_sec   = eng_wr_sec_q;
        bus.busy         = (state_q != IDLE);
        bus.state        = state_q;
    end
endmodule
